// File: rtl/alu_iter_pkg.sv
// Shared op codes, FSM states and op classification helpers for the iterative ALU.
package alu_iter_pkg;

  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_XOR   = 4'b0100;
  localparam logic [3:0] OP_XNOR  = 4'b0101;
  localparam logic [3:0] OP_SLTU  = 4'b0110;
  localparam logic [3:0] OP_MULLO = 4'b0111;
  localparam logic [3:0] OP_SUB   = 4'b1010;
  localparam logic [3:0] OP_SLT   = 4'b1011;
  localparam logic [3:0] OP_DIVU  = 4'b1100;
  localparam logic [3:0] OP_REMU  = 4'b1101;
  localparam logic [3:0] OP_MULHU = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2
  } state_e;

  function automatic logic is_mul_op(logic [3:0] op);
    return (op == OP_MULLO) || (op == OP_MULHU);
  endfunction

  function automatic logic is_div_op(logic [3:0] op);
    return (op == OP_DIVU) || (op == OP_REMU);
  endfunction

  function automatic logic is_multicycle(logic [3:0] op);
    return is_mul_op(op) || is_div_op(op);
  endfunction

endpackage

// File: rtl/alu_iter_comb.sv
// Single-cycle ALU slice: one shared adder serves ADD, SUB, SLT and SLTU.
module alu_iter_comb
  import alu_iter_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [3:0]       op_i,
  output logic [WIDTH-1:0] result_o,
  output logic             illegal_o
);

  logic             sub;
  logic [WIDTH-1:0] b_inv;
  logic [WIDTH:0]   sum;
  logic             overflow;
  logic             slt;
  logic             sltu;

  assign sub   = (op_i == OP_SUB) || (op_i == OP_SLT) || (op_i == OP_SLTU);
  assign b_inv = sub ? ~b_i : b_i;
  assign sum   = {1'b0, a_i} + {1'b0, b_inv} + {{WIDTH{1'b0}}, sub};

  // Signed compare must use the overflow-corrected sign, not the raw sum sign.
  assign overflow = (a_i[WIDTH-1] == b_inv[WIDTH-1]) && (sum[WIDTH-1] != a_i[WIDTH-1]);
  assign slt      = sum[WIDTH-1] ^ overflow;
  assign sltu     = ~sum[WIDTH];

  always_comb begin
    result_o  = '0;
    illegal_o = 1'b0;
    case (op_i)
      OP_AND:  result_o = a_i & b_i;
      OP_OR:   result_o = a_i | b_i;
      OP_XOR:  result_o = a_i ^ b_i;
      OP_XNOR: result_o = ~(a_i ^ b_i);
      OP_ADD,
      OP_SUB:  result_o = sum[WIDTH-1:0];
      OP_SLT:  result_o = {{(WIDTH-1){1'b0}}, slt};
      OP_SLTU: result_o = {{(WIDTH-1){1'b0}}, sltu};
      OP_MULLO, OP_MULHU, OP_DIVU, OP_REMU: result_o = '0;
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_iter.sv
// Handshaked EX-stage ALU: single-cycle ops via alu_iter_comb, iterative
// shift-add multiply and restoring divide taking WIDTH+1 cycles.
module alu_iter
  import alu_iter_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [3:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_zero,
  output logic             out_err
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [3:0]         op_q, op_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [WIDTH:0]     rem_q, rem_d;
  logic [WIDTH-1:0]   quo_q, quo_d;
  logic [WIDTH-1:0]   dvsr_q, dvsr_d;
  logic               dz_q, dz_d;
  logic               out_valid_q, out_valid_d;
  logic [WIDTH-1:0]   out_result_q, out_result_d;
  logic               out_zero_q, out_zero_d;
  logic               out_err_q, out_err_d;

  logic [WIDTH-1:0]   comb_res;
  logic               comb_illegal;

  alu_iter_comb #(.WIDTH(WIDTH)) u_comb (
    .a_i       (in_a),
    .b_i       (in_b),
    .op_i      (in_op),
    .result_o  (comb_res),
    .illegal_o (comb_illegal)
  );

  logic               last_iter;
  logic [2*WIDTH-1:0] acc_step;
  logic [WIDTH:0]     rem_shift, rem_diff, rem_step;
  logic               rem_ge;
  logic [WIDTH-1:0]   quo_step;
  logic [WIDTH-1:0]   mul_res, div_res;

  assign last_iter = (cnt_q == CNT_W'(WIDTH - 1));
  assign acc_step  = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

  // Quotient register doubles as the dividend shifter: its MSB feeds the remainder.
  assign rem_shift = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};
  assign rem_diff  = rem_shift - {1'b0, dvsr_q};
  assign rem_ge    = ~rem_diff[WIDTH];
  assign rem_step  = rem_ge ? rem_diff : rem_shift;
  assign quo_step  = {quo_q[WIDTH-2:0], rem_ge};

  assign mul_res = (op_q == OP_MULHU) ? acc_step[2*WIDTH-1:WIDTH] : acc_step[WIDTH-1:0];
  assign div_res = (op_q == OP_REMU) ? rem_step[WIDTH-1:0] : quo_step;

  assign in_ready   = (state_q == ST_IDLE) && (!out_valid_q || out_ready);
  assign out_valid  = out_valid_q;
  assign out_result = out_result_q;
  assign out_zero   = out_zero_q;
  assign out_err    = out_err_q;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    op_d         = op_q;
    acc_d        = acc_q;
    mcand_d      = mcand_q;
    mplier_d     = mplier_q;
    rem_d        = rem_q;
    quo_d        = quo_q;
    dvsr_d       = dvsr_q;
    dz_d         = dz_q;
    out_valid_d  = out_valid_q;
    out_result_d = out_result_q;
    out_zero_d   = out_zero_q;
    out_err_d    = out_err_q;

    if (out_valid_q && out_ready) out_valid_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (in_valid && in_ready) begin
          op_d  = in_op;
          cnt_d = '0;
          if (is_mul_op(in_op)) begin
            state_d  = ST_MUL;
            acc_d    = '0;
            mcand_d  = {{WIDTH{1'b0}}, in_a};
            mplier_d = in_b;
          end else if (is_div_op(in_op)) begin
            state_d = ST_DIV;
            rem_d   = '0;
            quo_d   = in_a;
            dvsr_d  = in_b;
            dz_d    = (in_b == '0);
          end else begin
            out_valid_d  = 1'b1;
            out_result_d = comb_res;
            out_zero_d   = (comb_res == '0);
            out_err_d    = comb_illegal;
          end
        end
      end
      ST_MUL: begin
        acc_d    = acc_step;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        if (last_iter) begin
          state_d      = ST_IDLE;
          cnt_d        = '0;
          out_valid_d  = 1'b1;
          out_result_d = mul_res;
          out_zero_d   = (mul_res == '0);
          out_err_d    = 1'b0;
        end
      end
      ST_DIV: begin
        rem_d = rem_step;
        quo_d = quo_step;
        cnt_d = cnt_q + 1'b1;
        // Divide by zero needs no special case: the loop yields all-ones and A.
        if (last_iter) begin
          state_d      = ST_IDLE;
          cnt_d        = '0;
          out_valid_d  = 1'b1;
          out_result_d = div_res;
          out_zero_d   = (div_res == '0);
          out_err_d    = dz_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      op_q         <= OP_AND;
      acc_q        <= '0;
      mcand_q      <= '0;
      mplier_q     <= '0;
      rem_q        <= '0;
      quo_q        <= '0;
      dvsr_q       <= '0;
      dz_q         <= 1'b0;
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_zero_q   <= 1'b1;
      out_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      op_q         <= op_d;
      acc_q        <= acc_d;
      mcand_q      <= mcand_d;
      mplier_q     <= mplier_d;
      rem_q        <= rem_d;
      quo_q        <= quo_d;
      dvsr_q       <= dvsr_d;
      dz_q         <= dz_d;
      out_valid_q  <= out_valid_d;
      out_result_q <= out_result_d;
      out_zero_q   <= out_zero_d;
      out_err_q    <= out_err_d;
    end
  end

endmodule

// File: tb/tb_alu_iter.sv
// Scoreboard bench for alu_iter at WIDTH=32, plus a WIDTH=8 multiply check.
module tb_alu_iter;
  import alu_iter_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready, out_zero, out_err;
  logic [31:0] in_a, in_b, out_result;
  logic [3:0]  in_op;

  logic        in_valid8, in_ready8, out_valid8, out_ready8, out_zero8, out_err8;
  logic [7:0]  in_a8, in_b8, out_result8;
  logic [3:0]  in_op8;

  alu_iter #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .out_valid(out_valid),
    .out_ready(out_ready), .out_result(out_result), .out_zero(out_zero), .out_err(out_err)
  );

  alu_iter #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
    .in_a(in_a8), .in_b(in_b8), .in_op(in_op8), .out_valid(out_valid8),
    .out_ready(out_ready8), .out_result(out_result8), .out_zero(out_zero8), .out_err(out_err8)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] res;
    logic        err;
    int          acc;
    int          lat;
  } exp_t;

  exp_t sb[$];
  bit   head_seen = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Monitor samples after the driver has settled its inputs for the coming edge.
  always begin
    @(negedge clk);
    #3;
    if (rst_n && out_valid) begin
      if (sb.size() == 0) begin
        check("spurious_valid", 64'(sb.size()), 64'(1));
      end else begin
        if (!head_seen) begin
          check("latency", 64'(cyc - sb[0].acc), 64'(sb[0].lat));
          head_seen = 1'b1;
        end
        if (out_ready) begin
          $display("result op_acc=%0d got=%08h exp=%08h err=%0b", sb[0].acc, out_result, sb[0].res, out_err);
          check("result", 64'(out_result), 64'(sb[0].res));
          check("zero", 64'(out_zero), 64'(sb[0].res == 32'd0));
          check("err", 64'(out_err), 64'(sb[0].err));
          void'(sb.pop_front());
          head_seen = 1'b0;
        end
      end
    end
  end

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op,
                      input logic ord, input logic [31:0] res, input logic err,
                      input int lat, output int acc);
    int   waited;
    exp_t e;
    waited = 0;
    @(negedge clk);
    #1;
    in_valid  = 1'b1;
    in_a      = a;
    in_b      = b;
    in_op     = op;
    out_ready = ord;
    #1;
    while (!in_ready && waited < 200) begin
      @(negedge clk);
      #2;
      waited++;
    end
    acc = cyc;
    if (!in_ready) begin
      check("accept_timeout", 64'(in_ready), 64'(1));
    end else begin
      e.res = res;
      e.err = err;
      e.acc = acc;
      e.lat = lat;
      sb.push_back(e);
    end
  endtask

  task automatic idle();
    @(negedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) check("drain_timeout", 64'(sb.size()), 64'(0));
  endtask

  task automatic mul8(input logic [3:0] op, input logic [7:0] exp);
    int n;
    @(negedge clk);
    #1;
    in_valid8 = 1'b1;
    in_a8     = 8'hFF;
    in_b8     = 8'hFF;
    in_op8    = op;
    #1;
    check("w8_ready", 64'(in_ready8), 64'(1));
    @(negedge clk);
    #1;
    in_valid8 = 1'b0;
    n = 1;
    while (!out_valid8 && n < 40) begin
      @(negedge clk);
      #1;
      n++;
    end
    $display("w8 op=%0h got=%02h exp=%02h lat=%0d", op, out_result8, exp, n);
    check("w8_latency", 64'(n), 64'(9));
    check("w8_result", 64'(out_result8), 64'(exp));
    check("w8_err", 64'(out_err8), 64'(0));
  endtask

  int acc0, acc1, acc_tmp;
  int accs[8];

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0; in_a = '0; in_b = '0; in_op = OP_AND; out_ready = 1'b1;
    in_valid8 = 1'b0; in_a8 = '0; in_b8 = '0; in_op8 = OP_AND; out_ready8 = 1'b1;
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    #2;
    check("rst_valid", 64'(out_valid), 64'(0));
    check("rst_zero", 64'(out_zero), 64'(1));
    check("rst_err", 64'(out_err), 64'(0));
    check("rst_result", 64'(out_result), 64'(0));
    check("rst_ready", 64'(in_ready), 64'(1));

    send(32'hFFFFFFFF, 32'd1, OP_ADD, 1'b1, 32'h0, 1'b0, 1, acc_tmp);
    send(32'd5, 32'd7, OP_SUB, 1'b1, 32'hFFFFFFFE, 1'b0, 1, acc_tmp);
    send(32'h80000000, 32'd1, OP_SLT, 1'b1, 32'd1, 1'b0, 1, acc_tmp);
    send(32'h80000000, 32'd1, OP_SLTU, 1'b1, 32'd0, 1'b0, 1, acc_tmp);
    send(32'h0, 32'h0, OP_XNOR, 1'b1, 32'hFFFFFFFF, 1'b0, 1, acc_tmp);
    send(32'hF0F0A5A5, 32'h0FF0FFFF, OP_AND, 1'b1, 32'h00F0A5A5, 1'b0, 1, acc_tmp);
    send(32'hF0F0A5A5, 32'h0FF00000, OP_OR, 1'b1, 32'hFFF0A5A5, 1'b0, 1, acc_tmp);
    send(32'hF0F0A5A5, 32'h0FF0FFFF, OP_XOR, 1'b1, 32'hFF005A5A, 1'b0, 1, acc_tmp);
    send(32'd1, 32'h80000000, OP_SLT, 1'b1, 32'd0, 1'b0, 1, acc_tmp);
    send(32'h1234, 32'h5678, 4'h3, 1'b1, 32'd0, 1'b1, 1, acc_tmp);
    send(32'h1234, 32'h5678, 4'h8, 1'b1, 32'd0, 1'b1, 1, acc_tmp);
    idle();
    drain();

    send(32'hFFFFFFFF, 32'hFFFFFFFF, OP_MULHU, 1'b1, 32'hFFFFFFFE, 1'b0, 33, acc_tmp);
    idle();
    #1 check("busy_ready", 64'(in_ready), 64'(0));
    repeat (31) begin
      @(negedge clk);
      #2;
      check("busy_ready", 64'(in_ready), 64'(0));
    end
    drain();
    send(32'hFFFFFFFF, 32'hFFFFFFFF, OP_MULLO, 1'b1, 32'd1, 1'b0, 33, acc_tmp);
    send(32'd100, 32'd7, OP_DIVU, 1'b1, 32'd14, 1'b0, 33, acc_tmp);
    send(32'd100, 32'd7, OP_REMU, 1'b1, 32'd2, 1'b0, 33, acc_tmp);
    send(32'h1234, 32'd0, OP_DIVU, 1'b1, 32'hFFFFFFFF, 1'b1, 33, acc_tmp);
    send(32'h1234, 32'd0, OP_REMU, 1'b1, 32'h1234, 1'b1, 33, acc_tmp);
    idle();
    drain();

    send(32'd3, 32'd4, OP_ADD, 1'b0, 32'd7, 1'b0, 1, acc0);
    idle();
    #1;
    check("bp_valid", 64'(out_valid), 64'(1));
    check("bp_result", 64'(out_result), 64'(7));
    check("bp_ready", 64'(in_ready), 64'(0));
    repeat (4) begin
      @(negedge clk);
      #2;
      check("bp_valid", 64'(out_valid), 64'(1));
      check("bp_result", 64'(out_result), 64'(7));
      check("bp_ready", 64'(in_ready), 64'(0));
    end
    send(32'd10, 32'd20, OP_ADD, 1'b1, 32'd30, 1'b0, 1, acc1);
    check("bp_accept_cycle", 64'(acc1 - acc0), 64'(6));
    idle();
    drain();

    for (int i = 0; i < 8; i++) begin
      send(32'(i * 3), 32'(i), OP_ADD, 1'b1, 32'(i * 4), 1'b0, 1, accs[i]);
    end
    idle();
    drain();
    for (int i = 1; i < 8; i++) begin
      check("stream_gap", 64'(accs[i] - accs[i-1]), 64'(1));
    end

    send(32'd100, 32'd7, OP_DIVU, 1'b1, 32'd14, 1'b0, 33, acc_tmp);
    repeat (9) @(negedge clk);
    #1;
    rst_n = 1'b0;
    in_valid = 1'b0;
    sb.delete();
    head_seen = 1'b0;
    #1;
    check("midrst_valid", 64'(out_valid), 64'(0));
    check("midrst_zero", 64'(out_zero), 64'(1));
    check("midrst_ready", 64'(in_ready), 64'(1));
    @(negedge clk);
    #1 rst_n = 1'b1;
    repeat (40) @(negedge clk);
    #1;
    check("midrst_no_stale", 64'(out_valid), 64'(0));
    send(32'd1, 32'd1, OP_ADD, 1'b1, 32'd2, 1'b0, 1, acc_tmp);
    idle();
    drain();

    mul8(OP_MULHU, 8'hFE);
    mul8(OP_MULLO, 8'h01);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
